// File: rtl/axi_ic_r.sv
// R-channel return path: per-master round-robin arbitration over slaves, with the grant
// locked for a whole burst, feeding a registered 2-entry skid buffer per master.
module axi_ic_r #(
  parameter int NumMasters = 2,
  parameter int NumSlaves = 2,
  parameter int AxiBusWidth = 128,
  parameter int IdWidth = 4,
  localparam int MasterSelWidth = ($clog2(NumMasters) == 0) ? 1 : $clog2(NumMasters),
  localparam int SlaveSelWidth = ($clog2(NumSlaves) == 0) ? 1 : $clog2(NumSlaves)
) (
  input  logic                                       aclk,
  input  logic                                       rst_n,
  input  logic [NumSlaves-1:0]                       s_rvalid_i,
  input  logic [NumSlaves-1:0][AxiBusWidth-1:0]      s_rdata_i,
  input  logic [NumSlaves-1:0][1:0]                  s_rresp_i,
  input  logic [NumSlaves-1:0][IdWidth-1:0]          s_rid_i,
  input  logic [NumSlaves-1:0]                       s_rlast_i,
  output logic [NumSlaves-1:0]                       s_rready_o,
  input  logic [NumSlaves-1:0][MasterSelWidth-1:0]   master_sel_i,
  output logic [NumMasters-1:0]                      m_rvalid_o,
  output logic [NumMasters-1:0][AxiBusWidth-1:0]     m_rdata_o,
  output logic [NumMasters-1:0][1:0]                 m_rresp_o,
  output logic [NumMasters-1:0][IdWidth-1:0]         m_rid_o,
  output logic [NumMasters-1:0]                      m_rlast_o,
  input  logic [NumMasters-1:0]                      m_rready_i,
  output logic [NumMasters-1:0][SlaveSelWidth-1:0]   rd_grant_o
);
  localparam int PayloadWidth = 1 + IdWidth + 2 + AxiBusWidth;

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_e;

  logic [NumMasters-1:0][NumSlaves-1:0] req_s;
  logic [NumMasters-1:0][NumSlaves-1:0] rdy_ms_s;

  function automatic logic [SlaveSelWidth-1:0] next_slave(input logic [SlaveSelWidth-1:0] g);
    if (g == SlaveSelWidth'(NumSlaves - 1)) begin
      next_slave = {SlaveSelWidth{1'b0}};
    end else begin
      next_slave = g + SlaveSelWidth'(1);
    end
  endfunction

  // A slave requests only the master its current beat is addressed to
  always_comb begin
    for (int m = 0; m < NumMasters; m++) begin
      for (int s = 0; s < NumSlaves; s++) begin
        req_s[m][s] = s_rvalid_i[s] && (master_sel_i[s] == MasterSelWidth'(m));
      end
    end
  end

  always_comb begin
    s_rready_o = {NumSlaves{1'b0}};
    for (int s = 0; s < NumSlaves; s++) begin
      for (int m = 0; m < NumMasters; m++) begin
        s_rready_o[s] = s_rready_o[s] | rdy_ms_s[m][s];
      end
    end
  end

  for (genvar m = 0; m < NumMasters; m++) begin : g_master
    state_e                    state_q, state_d;
    logic [SlaveSelWidth-1:0]  rr_q, rr_d, lock_q, lock_d, grant_q, grant_d, gnt_s;
    logic                      found_s, acc_s, in_last_s;
    logic [NumSlaves-1:0]      rdy_v_s;
    logic [PayloadWidth-1:0]   in_data_s;
    logic                      out_valid_q, out_valid_d, sk_valid_q, sk_valid_d, rdy_q, rdy_d;
    logic [PayloadWidth-1:0]   out_data_q, out_data_d, sk_data_q, sk_data_d;
    int                        idx;

    // Locked slave during a burst, otherwise first requester at or after rr
    always_comb begin
      gnt_s   = lock_q;
      found_s = 1'b0;
      idx     = 0;
      if (state_q == BURST) begin
        found_s = req_s[m][lock_q];
      end else begin
        for (int i = 0; i < NumSlaves; i++) begin
          idx = (int'(rr_q) + i) % NumSlaves;
          if (!found_s && req_s[m][idx]) begin
            found_s = 1'b1;
            gnt_s   = SlaveSelWidth'(idx);
          end
        end
      end
    end

    always_comb begin
      for (int s = 0; s < NumSlaves; s++) begin
        rdy_v_s[s] = rdy_q && found_s && (gnt_s == SlaveSelWidth'(s)) && req_s[m][s];
      end
    end

    assign rdy_ms_s[m] = rdy_v_s;
    assign acc_s       = |rdy_v_s;
    assign in_last_s   = s_rlast_i[gnt_s];
    assign in_data_s   = {s_rlast_i[gnt_s], s_rid_i[gnt_s], s_rresp_i[gnt_s], s_rdata_i[gnt_s]};

    // Burst lock and round-robin pointer update on accepted beats
    always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      lock_d  = lock_q;
      grant_d = found_s ? gnt_s : grant_q;
      case (state_q)
        IDLE: begin
          if (acc_s && in_last_s) begin
            rr_d = next_slave(gnt_s);
          end else if (acc_s) begin
            lock_d  = gnt_s;
            state_d = BURST;
          end else begin
            state_d = IDLE;
          end
        end
        BURST: begin
          if (acc_s && in_last_s) begin
            rr_d    = next_slave(lock_q);
            state_d = IDLE;
          end else begin
            state_d = BURST;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Skid: the spare entry absorbs the beat accepted while the output stalls
    always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      sk_valid_d  = sk_valid_q;
      sk_data_d   = sk_data_q;
      if (!out_valid_q || m_rready_i[m]) begin
        if (sk_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = sk_data_q;
          sk_valid_d  = 1'b0;
        end else begin
          out_valid_d = acc_s;
          out_data_d  = acc_s ? in_data_s : out_data_q;
        end
      end else if (acc_s) begin
        sk_valid_d = 1'b1;
        sk_data_d  = in_data_s;
      end else begin
        sk_valid_d = sk_valid_q;
      end
      rdy_d = !sk_valid_d;
    end

    // State and datapath registers; ready comes up one cycle after reset release
    always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
        state_q     <= IDLE;
        rr_q        <= {SlaveSelWidth{1'b0}};
        lock_q      <= {SlaveSelWidth{1'b0}};
        grant_q     <= {SlaveSelWidth{1'b0}};
        out_valid_q <= 1'b0;
        out_data_q  <= {PayloadWidth{1'b0}};
        sk_valid_q  <= 1'b0;
        sk_data_q   <= {PayloadWidth{1'b0}};
        rdy_q       <= 1'b0;
      end else begin
        state_q     <= state_d;
        rr_q        <= rr_d;
        lock_q      <= lock_d;
        grant_q     <= grant_d;
        out_valid_q <= out_valid_d;
        out_data_q  <= out_data_d;
        sk_valid_q  <= sk_valid_d;
        sk_data_q   <= sk_data_d;
        rdy_q       <= rdy_d;
      end
    end

    assign m_rvalid_o[m] = out_valid_q;
    assign {m_rlast_o[m], m_rid_o[m], m_rresp_o[m], m_rdata_o[m]} = out_data_q;
    assign rd_grant_o[m] = grant_q;
  end

endmodule

// File: tb/tb_axi_ic_r.sv
// Directed bench for axi_ic_r: slave beat tables replayed on handshake, master beats logged.
module tb_axi_ic_r;
  localparam int NM = 2;
  localparam int NS = 2;
  localparam int W  = 128;
  localparam int IW = 4;

  logic                    aclk, rst_n;
  logic [NS-1:0]           s_rvalid;
  logic [NS-1:0][W-1:0]    s_rdata;
  logic [NS-1:0][1:0]      s_rresp;
  logic [NS-1:0][IW-1:0]   s_rid;
  logic [NS-1:0]           s_rlast;
  logic [NS-1:0]           s_rready_o;
  logic [NS-1:0][0:0]      master_sel;
  logic [NM-1:0]           m_rvalid_o;
  logic [NM-1:0][W-1:0]    m_rdata_o;
  logic [NM-1:0][1:0]      m_rresp_o;
  logic [NM-1:0][IW-1:0]   m_rid_o;
  logic [NM-1:0]           m_rlast_o;
  logic [NM-1:0]           m_rready;
  logic [NM-1:0][0:0]      rd_grant_o;

  int checks, failures, cyc;

  logic [W-1:0]  tb_data [NS][128];
  logic [IW-1:0] tb_id   [NS][128];
  logic          tb_last [NS][128];
  logic          tb_sel  [NS][128];
  int            n_b [NS];
  int            ptr [NS];

  logic [W-1:0]  lg_data [NM][128];
  logic          lg_last [NM][128];
  int            lg_cyc  [NM][128];
  int            n_lg [NM];

  axi_ic_r #(.NumMasters(NM), .NumSlaves(NS), .AxiBusWidth(W), .IdWidth(IW)) dut (
    .aclk(aclk), .rst_n(rst_n),
    .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .s_rresp_i(s_rresp), .s_rid_i(s_rid),
    .s_rlast_i(s_rlast), .s_rready_o(s_rready_o), .master_sel_i(master_sel),
    .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o), .m_rresp_o(m_rresp_o), .m_rid_o(m_rid_o),
    .m_rlast_o(m_rlast_o), .m_rready_i(m_rready), .rd_grant_o(rd_grant_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [W-1:0] mk_data(input int s, input int b);
    mk_data = {32'hC0DE_0000, 32'(s), 32'(b), 32'h5A5A_5A5A};
  endfunction

  task automatic clear_all();
    for (int s = 0; s < NS; s++) begin n_b[s] = 0; ptr[s] = 0; end
    for (int m = 0; m < NM; m++) n_lg[m] = 0;
  endtask

  task automatic load_burst(input int s, input int sel, input int n, input bit single);
    for (int b = 0; b < n; b++) begin
      tb_data[s][n_b[s]] = mk_data(s, b);
      tb_id[s][n_b[s]]   = IW'(s + 1);
      tb_sel[s][n_b[s]]  = sel[0];
      tb_last[s][n_b[s]] = single ? 1'b1 : (b == n - 1);
      n_b[s]++;
    end
  endtask

  task automatic drive_slaves();
    for (int s = 0; s < NS; s++) begin
      if (ptr[s] < n_b[s]) begin
        s_rvalid[s]   = 1'b1;
        s_rdata[s]    = tb_data[s][ptr[s]];
        s_rid[s]      = tb_id[s][ptr[s]];
        s_rlast[s]    = tb_last[s][ptr[s]];
        master_sel[s] = tb_sel[s][ptr[s]];
      end else begin
        s_rvalid[s]   = 1'b0;
        s_rdata[s]    = '0;
        s_rid[s]      = '0;
        s_rlast[s]    = 1'b0;
        master_sel[s] = 1'b0;
      end
      s_rresp[s] = 2'b00;
    end
  endtask

  task automatic tick();
    logic [NS-1:0] hs;
    @(negedge aclk);
    hs = s_rvalid & s_rready_o;
    for (int m = 0; m < NM; m++) begin
      if (m_rvalid_o[m] && m_rready[m] && n_lg[m] < 128) begin
        lg_data[m][n_lg[m]] = m_rdata_o[m];
        lg_last[m][n_lg[m]] = m_rlast_o[m];
        lg_cyc[m][n_lg[m]]  = cyc;
        n_lg[m]++;
      end
    end
    @(posedge aclk);
    cyc++;
    #1;
    for (int s = 0; s < NS; s++) if (hs[s]) ptr[s]++;
    drive_slaves();
  endtask

  task automatic run_until(input int m, input int cnt, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (n_lg[m] >= cnt) break;
      tick();
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    clear_all();
    m_rready = 2'b11;
    drive_slaves();
    repeat (2) @(posedge aclk);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    clear_all();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_all();
    m_rready = 2'b11;
    load_burst(0, 0, 1, 1'b1);
    drive_slaves();
    #1;
    checks++;
    if (m_rvalid_o !== 2'b00 || s_rready_o !== 2'b00 || rd_grant_o !== 2'b00) begin
      failures++;
      $display("FAIL reset_outputs: rvalid=%b rready=%b grant=%b, required 00/00/00", m_rvalid_o, s_rready_o, rd_grant_o);
    end
    tick(); tick();
    checks++;
    if (s_rready_o !== 2'b00) begin
      failures++;
      $display("FAIL reset_rready_held: got %b, required 00", s_rready_o);
    end
    reset_dut();
  endtask

  task automatic test_single();
    reset_dut();
    tb_data[0][0] = {16{8'hA5}};
    tb_id[0][0]   = 4'd3;
    tb_sel[0][0]  = 1'b1;
    tb_last[0][0] = 1'b1;
    n_b[0] = 1;
    drive_slaves();
    #1;
    checks++;
    if (s_rready_o !== 2'b01) begin
      failures++;
      $display("FAIL single_rready: got %b, required 01", s_rready_o);
    end
    tick();
    #1;
    checks++;
    if (m_rvalid_o !== 2'b10 || m_rdata_o[1] !== {16{8'hA5}} || m_rid_o[1] !== 4'd3 || m_rlast_o[1] !== 1'b1) begin
      failures++;
      $display("FAIL single_out: rvalid=%b data=%h id=%0d last=%b, required 10/a5../3/1", m_rvalid_o, m_rdata_o[1], m_rid_o[1], m_rlast_o[1]);
    end
    tick();
    #1;
    checks++;
    if (n_lg[1] !== 1 || n_lg[0] !== 0 || m_rvalid_o !== 2'b00) begin
      failures++;
      $display("FAIL single_count: m1=%0d m0=%0d rvalid=%b, required 1/0/00", n_lg[1], n_lg[0], m_rvalid_o);
    end
  endtask

  task automatic test_contention();
    reset_dut();
    load_burst(0, 0, 4, 1'b0);
    load_burst(1, 0, 4, 1'b0);
    drive_slaves();
    #1;
    checks++;
    if (s_rready_o !== 2'b01) begin
      failures++;
      $display("FAIL contention_first_grant: got %b, required 01", s_rready_o);
    end
    tick(); tick();
    #1;
    checks++;
    if (rd_grant_o[0] !== 1'b0 || s_rready_o !== 2'b01) begin
      failures++;
      $display("FAIL contention_lock: grant=%b rready=%b, required 0/01", rd_grant_o[0], s_rready_o);
    end
    run_until(0, 8, 40);
    checks++;
    if (n_lg[0] !== 8 || n_lg[1] !== 0) begin
      failures++;
      $display("FAIL contention_count: m0=%0d m1=%0d, required 8/0", n_lg[0], n_lg[1]);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (lg_data[0][i] !== mk_data(i / 4, i % 4)) begin
        failures++;
        $display("FAIL contention_order[%0d]: got %h, required %h", i, lg_data[0][i], mk_data(i / 4, i % 4));
      end
    end
    checks++;
    if (lg_last[0][3] !== 1'b1 || lg_last[0][2] !== 1'b0 || lg_last[0][7] !== 1'b1) begin
      failures++;
      $display("FAIL contention_rlast: b2=%b b3=%b b7=%b, required 0/1/1", lg_last[0][2], lg_last[0][3], lg_last[0][7]);
    end
    checks++;
    if (rd_grant_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL contention_grant_end: got %b, required 1", rd_grant_o[0]);
    end
  endtask

  task automatic test_round_robin();
    int n0;
    reset_dut();
    load_burst(0, 0, 50, 1'b1);
    load_burst(1, 0, 50, 1'b1);
    drive_slaves();
    run_until(0, 100, 250);
    checks++;
    if (n_lg[0] !== 100) begin
      failures++;
      $display("FAIL rr_count: got %0d, required 100", n_lg[0]);
    end
    n0 = 0;
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (lg_data[0][i] !== mk_data(i % 2, i / 2)) begin
        failures++;
        $display("FAIL rr_order[%0d]: got %h, required %h", i, lg_data[0][i], mk_data(i % 2, i / 2));
      end
      if (lg_data[0][i][95:64] == 32'd0) n0++;
    end
    checks++;
    if (n0 < 49 || n0 > 51) begin
      failures++;
      $display("FAIL rr_share: s0 beats=%0d, required 49..51", n0);
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    load_burst(0, 0, 8, 1'b0);
    drive_slaves();
    run_until(0, 2, 20);
    m_rready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      checks++;
      if (m_rvalid_o[0] !== 1'b1 || m_rdata_o[0] !== mk_data(0, 2)) begin
        failures++;
        $display("FAIL bp_stable[%0d]: rvalid=%b data=%h, required 1/%h", k, m_rvalid_o[0], m_rdata_o[0], mk_data(0, 2));
      end
    end
    checks++;
    if (s_rready_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_rready_drop: got %b, required 0", s_rready_o[0]);
    end
    m_rready = 2'b11;
    run_until(0, 8, 40);
    checks++;
    if (n_lg[0] !== 8) begin
      failures++;
      $display("FAIL bp_count: got %0d, required 8", n_lg[0]);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (lg_data[0][i] !== mk_data(0, i)) begin
        failures++;
        $display("FAIL bp_order[%0d]: got %h, required %h", i, lg_data[0][i], mk_data(0, i));
      end
    end
    for (int i = 2; i < 7; i++) begin
      checks++;
      if (lg_cyc[0][i + 1] !== lg_cyc[0][i] + 1) begin
        failures++;
        $display("FAIL bp_rate[%0d]: cycles %0d->%0d, required consecutive", i, lg_cyc[0][i], lg_cyc[0][i + 1]);
      end
    end
  endtask

  task automatic test_parallel();
    int c0;
    reset_dut();
    load_burst(0, 0, 8, 1'b0);
    load_burst(1, 1, 8, 1'b0);
    drive_slaves();
    c0 = cyc;
    run_until(0, 8, 30);
    run_until(1, 8, 10);
    for (int m = 0; m < NM; m++) begin
      checks++;
      if (n_lg[m] !== 8 || lg_cyc[m][0] !== c0 + 1 || lg_cyc[m][7] !== c0 + 8) begin
        failures++;
        $display("FAIL parallel_timing[m%0d]: count=%0d first=%0d last=%0d, required 8/%0d/%0d", m, n_lg[m], lg_cyc[m][0], lg_cyc[m][7], c0 + 1, c0 + 8);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (lg_data[m][i] !== mk_data(m, i)) begin
          failures++;
          $display("FAIL parallel_data[m%0d][%0d]: got %h, required %h", m, i, lg_data[m][i], mk_data(m, i));
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    reset_dut();
    load_burst(0, 0, 4, 1'b0);
    drive_slaves();
    for (int k = 0; k < 10; k++) begin
      if (ptr[0] >= 2) break;
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_rvalid_o !== 2'b00 || s_rready_o !== 2'b00 || rd_grant_o !== 2'b00 || ptr[0] !== 2) begin
      failures++;
      $display("FAIL midreset_clear: rvalid=%b rready=%b grant=%b ptr=%0d, required 00/00/00/2", m_rvalid_o, s_rready_o, rd_grant_o, ptr[0]);
    end
    clear_all();
    load_burst(1, 0, 2, 1'b0);
    drive_slaves();
    tick(); tick();
    rst_n = 1'b1;
    run_until(0, 2, 20);
    checks++;
    if (n_lg[0] !== 2 || lg_data[0][0] !== mk_data(1, 0) || lg_data[0][1] !== mk_data(1, 1)) begin
      failures++;
      $display("FAIL midreset_after: count=%0d d0=%h d1=%h, required 2/%h/%h", n_lg[0], lg_data[0][0], lg_data[0][1], mk_data(1, 0), mk_data(1, 1));
    end
    checks++;
    if (rd_grant_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL midreset_grant: got %b, required 1", rd_grant_o[0]);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    rst_n = 1'b0;
    m_rready = 2'b11;
    clear_all();
    drive_slaves();
    test_reset();
    test_single();
    test_contention();
    test_round_robin();
    test_backpressure();
    test_parallel();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
